aes_key_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_key_round.sv | 35 +++
 rtl/aes_key_sched.sv | 130 +++++++++++++
 tb/tb_aes_key_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, state encoding,
// the round-key bus type, and the Rcon and forward S-box functions.
package aes_pkg;

  localparam logic [3:0] AES_NR128 = 4'd10;

  // Exponent 254 gives the multiplicative inverse in GF(2^8).
  localparam logic [7:0] GF_INV_EXP = 8'hFE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  typedef struct packed {
    logic         vld;
    logic [127:0] key;
  } rk_bus_t;

  // Round constant for rounds 1..10; other indices return 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] aes_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = aes_xtime(t);
    end
    return p;
  endfunction

  // Forward S-box: inverse in GF(2^8) (0 maps to 0) followed by the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = aes_gmul(r, r);
      if (GF_INV_EXP[i]) r = aes_gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational AES-128 next-round-key function. Holds the single SubWord
// unit (four S-boxes) that every expansion round reuses.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[31:0];
  assign w1 = key_i[63:32];
  assign w2 = key_i[95:64];
  assign w3 = key_i[127:96];

  // Byte 0 sits in the low bits, so RotWord moves byte 0 to the top.
  assign rot_w = {w3[7:0], w3[31:8]};

  assign sub_w = {aes_sbox(rot_w[31:24]), aes_sbox(rot_w[23:16]),
                  aes_sbox(rot_w[15:8]),  aes_sbox(rot_w[7:0])};

  assign t_w = sub_w ^ {24'h0, rcon_i};

  assign n0 = w0 ^ t_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 round-key scheduler and key bank. Accepts a cipher key over
// key_req/key_ack, expands one round key per cycle into the bank, and serves
// {valid, round_key} to the core combinationally by round address.
// Optional build macro AES_KEYSCHED_ZEROIZE_EN adds a zeroize input that
// wipes the bank and returns the scheduler to IDLE.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_KEYSCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_req,
  input  logic [127:0] key_in,
  output logic         key_ack,
  input  logic         core_busy,
  input  logic [3:0]   rk_addr,
  output logic [128:0] rk_out,
  output logic [3:0]   nr_o,
  output logic         sched_busy
);

  ks_state_e    state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         bank_vld_q, bank_vld_d;
  logic         key_ack_q, key_ack_d;
  logic [127:0] bank_q [NR+1];
  logic [127:0] bank_d [NR+1];

  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [7:0]   rcon;
  logic         zero_req;
  logic         accept;
  rk_bus_t      rk_bus;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // A busy core always wins, so a key never changes under an in-flight block.
  assign accept = key_req & (state_q != EXPAND) & ~core_busy & ~zero_req;

  assign rcon = aes_rcon(rnd_q);

  // Select bank[rnd-1] as the source of the round being expanded.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (rnd_q == 4'(i + 1)) prev_key = bank_q[i];
    end
  end

  aes_key_round u_round (
    .key_i  (prev_key),
    .rcon_i (rcon),
    .key_o  (next_key)
  );

  // Next-state logic for the controller and the key bank.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    bank_vld_d = bank_vld_q;
    key_ack_d  = 1'b0;
    for (int i = 0; i <= NR; i++) bank_d[i] = bank_q[i];

    if (zero_req) begin
      state_d    = IDLE;
      rnd_d      = '0;
      bank_vld_d = 1'b0;
      for (int i = 0; i <= NR; i++) bank_d[i] = '0;
    end else if (accept) begin
      state_d    = EXPAND;
      rnd_d      = 4'd1;
      bank_vld_d = 1'b0;
      key_ack_d  = 1'b1;
      bank_d[0]  = key_in;
    end else if (state_q == EXPAND) begin
      for (int i = 1; i <= NR; i++) begin
        if (rnd_q == 4'(i)) bank_d[i] = next_key;
      end
      if (rnd_q == 4'(NR)) begin
        state_d    = READY;
        bank_vld_d = 1'b1;
      end else begin
        rnd_d = rnd_q + 4'd1;
      end
    end
  end

  // State, bank and handshake registers; reset also wipes the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      bank_vld_q <= 1'b0;
      key_ack_q  <= 1'b0;
      for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      bank_vld_q <= bank_vld_d;
      key_ack_q  <= key_ack_d;
      for (int i = 0; i <= NR; i++) bank_q[i] <= bank_d[i];
    end
  end

  // Read port: addresses beyond NR decode to nothing and return all zeros.
  always_comb begin
    rk_bus = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_addr == 4'(i)) begin
        rk_bus.vld = bank_vld_q;
        rk_bus.key = bank_q[i];
      end
    end
  end

  assign rk_out     = rk_bus;
  assign key_ack    = key_ack_q;
  assign sched_busy = (state_q == EXPAND);
  assign nr_o       = 4'(NR);

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: known-answer round keys from FIPS-197 vectors,
// handshake latency, stall, blocking, reset and (when built with
// AES_KEYSCHED_ZEROIZE_EN) zeroize sequences.
module tb_aes_key_sched;

  localparam int NR_T = 10;

  localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_Z    = 128'h0;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst;
  logic         key_req;
  logic [127:0] key_in;
  logic         key_ack;
  logic         core_busy;
  logic [3:0]   rk_addr;
  logic [128:0] rk_out;
  logic [3:0]   nr_o;
  logic         sched_busy;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int total;
  int bad;
  logic [128:0] sb_q [$];

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] exp;
    string        nm;
  } vec_t;

  vec_t vecs [8];

  aes_key_sched #(.NR(NR_T)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AES_KEYSCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_req    (key_req),
    .key_in     (key_in),
    .key_ack    (key_ack),
    .core_busy  (core_busy),
    .rk_addr    (rk_addr),
    .rk_out     (rk_out),
    .nr_o       (nr_o),
    .sched_busy (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end, got running required done");
    $fatal(1, "watchdog");
  end

  // FIPS hex strings list byte 0 first; the DUT puts byte 0 in the low bits.
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Scoreboarded read: expectation queued as the address is driven.
  task automatic rd(input logic [3:0] a, input logic [127:0] fips, input logic v,
                    input string nm);
    logic [128:0] e;
    sb_q.push_back({v, bswap(fips)});
    rk_addr = a;
    #1;
    e = sb_q.pop_front();
    chk(nm, rk_out, e);
  endtask

  // Called one step after the accept edge; follows the expansion to READY.
  task automatic expand_tail(input string nm);
    chk({nm, " ack"}, 129'(key_ack), 129'd1);
    chk({nm, " vld after ack"}, 129'(rk_out[128]), 129'd0);
    chk({nm, " busy after ack"}, 129'(sched_busy), 129'd1);
    for (int c = 2; c <= NR_T; c++) begin
      tick();
      if (c == 2) chk({nm, " ack pulse"}, 129'(key_ack), 129'd0);
      chk({nm, " stall vld"}, 129'(rk_out[128]), 129'd0);
      chk({nm, " stall busy"}, 129'(sched_busy), 129'd1);
    end
    tick();
    chk({nm, " ready vld"}, 129'(rk_out[128]), 129'd1);
    chk({nm, " ready busy"}, 129'(sched_busy), 129'd0);
  endtask

  task automatic load(input logic [127:0] k, input string nm);
    rk_addr = 4'd0;
    key_in  = bswap(k);
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    expand_tail(nm);
  endtask

  initial begin
    logic [127:0] cur;
    logic         have;
    int           n;
    logic         got;

    total = 0;
    bad   = 0;
    rst       = 1'b1;
    key_req   = 1'b0;
    key_in    = '0;
    core_busy = 1'b0;
    rk_addr   = 4'd0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif

    vecs[0] = '{K_A1, 4'd0,  K_A1,   "A1 rk0"};
    vecs[1] = '{K_A1, 4'd1,  A1_R1,  "A1 rk1"};
    vecs[2] = '{K_A1, 4'd10, A1_R10, "A1 rk10"};
    vecs[3] = '{K_C1, 4'd1,  C1_R1,  "C1 rk1"};
    vecs[4] = '{K_C1, 4'd10, C1_R10, "C1 rk10"};
    vecs[5] = '{K_Z,  4'd0,  K_Z,    "Z rk0"};
    vecs[6] = '{K_Z,  4'd1,  Z_R1,   "Z rk1"};
    vecs[7] = '{K_Z,  4'd10, Z_R10,  "Z rk10"};

    // Reset state
    tick();
    tick();
    chk("rst key_ack", 129'(key_ack), 129'd0);
    chk("rst sched_busy", 129'(sched_busy), 129'd0);
    chk("rst nr_o", 129'(nr_o), 129'd10);
    rd(4'd0, 128'h0, 1'b0, "rst rk0");
    rd(4'd5, 128'h0, 1'b0, "rst rk5");
    rst = 1'b0;
    tick();
    chk("idle sched_busy", 129'(sched_busy), 129'd0);

    // Known-answer table
    have = 1'b0;
    cur  = '0;
    for (int v = 0; v < 8; v++) begin
      if (!have || cur != vecs[v].key) begin
        load(vecs[v].key, {vecs[v].nm, " load"});
        cur  = vecs[v].key;
        have = 1'b1;
      end
      rd(vecs[v].addr, vecs[v].exp, 1'b1, vecs[v].nm);
    end

    // Out-of-range addresses in READY
    load(K_A1, "A1 reload");
    for (int a = 11; a <= 15; a++) rd(4'(a), 128'h0, 1'b0, "oob addr");

    // Key change blocked by a busy core; request and busy rise together
    rk_addr   = 4'd0;
    core_busy = 1'b1;
    key_in    = bswap(K_C1);
    key_req   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("blocked ack", 129'(key_ack), 129'd0);
      chk("blocked busy", 129'(sched_busy), 129'd0);
    end
    rd(4'd10, A1_R10, 1'b1, "blocked old rk10");
    rd(4'd1, A1_R1, 1'b1, "blocked old rk1");
    rk_addr   = 4'd0;
    core_busy = 1'b0;
    tick();
    key_req = 1'b0;
    expand_tail("unblocked");
    rd(4'd10, C1_R10, 1'b1, "unblocked rk10");

    // Second request held from the third expansion cycle
    rk_addr = 4'd0;
    key_in  = bswap(K_A1);
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    chk("pend first ack", 129'(key_ack), 129'd1);
    tick();
    tick();
    key_in  = bswap(K_C1);
    key_req = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (key_ack) got = 1'b1;
    end
    chk("pend ack cycles", 129'(n), 129'd9);
    key_req = 1'b0;
    expand_tail("pend");
    rd(4'd1, C1_R1, 1'b1, "pend rk1");
    rd(4'd10, C1_R10, 1'b1, "pend rk10");

    // Reset at rnd=5
    rk_addr = 4'd0;
    key_in  = bswap(K_A1);
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("mid busy", 129'(sched_busy), 129'd1);
    rst = 1'b1;
    #1;
    chk("mid rst rk_out", rk_out, 129'd0);
    chk("mid rst busy", 129'(sched_busy), 129'd0);
    rd(4'd3, 128'h0, 1'b0, "mid rst rk3");
    tick();
    rst = 1'b0;
    tick();
    load(K_A1, "after rst");
    rd(4'd0, K_A1, 1'b1, "after rst rk0");
    rd(4'd1, A1_R1, 1'b1, "after rst rk1");
    rd(4'd10, A1_R10, 1'b1, "after rst rk10");

`ifdef AES_KEYSCHED_ZEROIZE_EN
    // Zeroize in READY
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero busy", 129'(sched_busy), 129'd0);
    for (int a = 0; a <= NR_T; a++) rd(4'(a), 128'h0, 1'b0, "zero bank");

    // Zeroize coinciding with a request
    load(K_A1, "zero reload");
    rk_addr = 4'd0;
    key_in  = bswap(K_C1);
    key_req = 1'b1;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero+req ack", 129'(key_ack), 129'd0);
    chk("zero+req rk_out", rk_out, 129'd0);
    tick();
    key_req = 1'b0;
    expand_tail("after zero");
    rd(4'd10, C1_R10, 1'b1, "after zero rk10");

    // Zeroize while the core is busy
    core_busy = 1'b1;
    zeroize   = 1'b1;
    tick();
    zeroize   = 1'b0;
    rd(4'd10, 128'h0, 1'b0, "zero busy core rk10");
    core_busy = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
